// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle EX holds and
// taken-branch flushes, with saturating stall/flush statistics.
module hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_mc_op,
    input  logic              ex_branch_taken,
    input  logic              mc_done,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_hold,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              mc_start,
    output logic              mc_error,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          err_q, err_d;
    logic          flush_evt;
    logic          load_use;
    logic          timeout;

    assign load_use = ex_memread & ex_regwrite &
                      ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
    assign timeout  = (timer_q == TW'(MC_TIMEOUT - 1));
    assign mc_error = err_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fcnt_d       = fcnt_q;
        err_d        = err_q;
        flush_evt    = 1'b0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mc_start     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_evt   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FW'(FLUSH_CYCLES - 1);
                    end
                end else if (ex_mc_op) begin
                    mc_start     = 1'b1;
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    timer_d      = '0;
                    state_d      = ST_MC_WAIT;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                // A done pulse on the timeout cycle still counts as success.
                if (mc_done) begin
                    state_d = ST_RUN;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    timer_d      = timer_q + TW'(1);
                end
            end
            ST_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                fcnt_d      = fcnt_q - FW'(1);
                if (fcnt_q <= FW'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            ifid_flush   = 1'b0;
            idex_hold    = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            mc_start     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            fcnt_q    <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] id_rs, id_rt, ex_rt;
    logic id_uses_rs, id_uses_rt, ex_memread, ex_regwrite, ex_mc_op, ex_branch_taken, mc_done;
    logic pc_stall, ifid_stall, ifid_flush, idex_hold, idex_bubble, exmem_bubble, mc_start;
    logic mc_error;
    logic [15:0] stall_cnt, flush_cnt;
    // Narrow-counter instance for saturation checks.
    logic pc_stall4, ifid_stall4, ifid_flush4, idex_hold4, idex_bubble4, exmem_bubble4;
    logic mc_start4, mc_error4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(FC), .MC_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_rt(ex_rt), .ex_mc_op(ex_mc_op), .ex_branch_taken(ex_branch_taken),
        .mc_done(mc_done), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .mc_start(mc_start), .mc_error(mc_error),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(FC), .MC_TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_rt(ex_rt), .ex_mc_op(ex_mc_op), .ex_branch_taken(ex_branch_taken),
        .mc_done(mc_done), .pc_stall(pc_stall4), .ifid_stall(ifid_stall4),
        .ifid_flush(ifid_flush4), .idex_hold(idex_hold4), .idex_bubble(idex_bubble4),
        .exmem_bubble(exmem_bubble4), .mc_start(mc_start4), .mc_error(mc_error4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Model: how long the multi-cycle op has been waiting (-1 = none), wrong-path
    // cycles still to squash, sticky error and plain integer statistics.
    int mc_age = -1;
    int flush_left = 0;
    int m_err = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    always @(negedge clk) begin
        int e_pc, e_ifs, e_iff, e_hold, e_bub, e_exb, e_start;
        int hit;
        e_pc = 0; e_ifs = 0; e_iff = 0; e_hold = 0; e_bub = 0; e_exb = 0; e_start = 0;
        hit = ex_memread && ex_regwrite &&
              ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        if (!rst) begin
            if (flush_left > 0) begin
                e_iff = 1; e_bub = 1;
            end else if (mc_age >= 0) begin
                if (!mc_done && mc_age < TO - 1) begin
                    e_pc = 1; e_ifs = 1; e_hold = 1; e_exb = 1;
                end
            end else if (ex_branch_taken) begin
                e_iff = 1; e_bub = 1;
            end else if (ex_mc_op) begin
                e_start = 1; e_pc = 1; e_ifs = 1; e_hold = 1; e_exb = 1;
            end else if (hit) begin
                e_pc = 1; e_ifs = 1; e_bub = 1;
            end
        end
        chk("pc_stall", int'(pc_stall), e_pc);
        chk("ifid_stall", int'(ifid_stall), e_ifs);
        chk("ifid_flush", int'(ifid_flush), e_iff);
        chk("idex_hold", int'(idex_hold), e_hold);
        chk("idex_bubble", int'(idex_bubble), e_bub);
        chk("exmem_bubble", int'(exmem_bubble), e_exb);
        chk("mc_start", int'(mc_start), e_start);
        chk("mc_error", int'(mc_error), m_err);
        chk("stall_cnt", int'(stall_cnt), (m_stalls > 65535) ? 65535 : m_stalls);
        chk("flush_cnt", int'(flush_cnt), (m_flushes > 65535) ? 65535 : m_flushes);
        chk("stall_cnt4", int'(stall_cnt4), (m_stalls > 15) ? 15 : m_stalls);

        if (rst) begin
            mc_age = -1; flush_left = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (flush_left > 0) begin
                flush_left--;
            end else if (mc_age >= 0) begin
                if (mc_done) mc_age = -1;
                else if (mc_age == TO - 1) begin mc_age = -1; m_err = 1; end
                else mc_age++;
            end else if (ex_branch_taken) begin
                m_flushes++;
                flush_left = FC - 1;
            end else if (ex_mc_op) begin
                mc_age = 0;
            end
            m_stalls += e_pc;
        end
    end

    task automatic drive(input logic r, input logic [2:0] rs, input logic urs, input logic mr,
                         input logic [2:0] ert, input logic mc, input logic br, input logic dn);
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = 3'd0; id_uses_rs = urs; id_uses_rt = 1'b0;
        ex_memread = mr; ex_regwrite = mr; ex_rt = ert;
        ex_mc_op = mc; ex_branch_taken = br; mc_done = dn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
        ex_memread = 0; ex_regwrite = 0; ex_mc_op = 0; ex_branch_taken = 0; mc_done = 0;

        // Load-use stall, then the same pair with rs not read.
        do_reset();
        drive(1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_pc_stall", int'(pc_stall), 1);
        chk("lu_bubble", int'(idex_bubble), 1);
        drive(1'b0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_nouse_stall", int'(pc_stall), 0);
        chk("lu_stall_cnt", int'(stall_cnt), 1);

        // Multi-cycle op completing after six stall cycles.
        do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("mc_start_pulse", int'(mc_start), 1);
        idle(5);
        #1 chk("mc_wait_start_low", int'(mc_start), 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("mc_done_release", int'(pc_stall), 0);
        idle(1);
        #1 chk("mc_stall_cnt", int'(stall_cnt), 6);
        chk("mc_no_error", int'(mc_error), 0);

        // Timeout: 64 stall cycles, sticky error, later done ignored.
        do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(70);
        #1 chk("to_error", int'(mc_error), 1);
        chk("to_stall_cnt", int'(stall_cnt), 64);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("to_late_done", int'(pc_stall), 0);

        // Branch beats mc_op and load-use in the same cycle.
        do_reset();
        drive(1'b0, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        #1 chk("br_flush0", int'(ifid_flush), 1);
        chk("br_no_stall", int'(pc_stall), 0);
        chk("br_no_start", int'(mc_start), 0);
        idle(1);
        #1 chk("br_flush1", int'(ifid_flush), 1);
        idle(1);
        #1 chk("br_flush_end", int'(ifid_flush), 0);
        chk("br_flush_cnt", int'(flush_cnt), 1);

        // Reset during the third MC_WAIT cycle.
        do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("rst_mid_stall", int'(pc_stall), 0);
        idle(1);
        #1 chk("rst_after_stall", int'(pc_stall), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);

        // Saturation of the 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        idle(1);
        #1 chk("sat_cnt4", int'(stall_cnt4), 15);
        chk("sat_cnt16", int'(stall_cnt), 20);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst             = ($urandom_range(0, 999) < 4);
            id_rs           = 3'($urandom_range(0, 3));
            id_rt           = 3'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_memread      = ($urandom_range(0, 99) < 40);
            ex_regwrite     = ($urandom_range(0, 99) < 70);
            ex_rt           = 3'($urandom_range(0, 3));
            ex_mc_op        = ($urandom_range(0, 99) < 8);
            ex_branch_taken = ($urandom_range(0, 99) < 8);
            mc_done         = ($urandom_range(0, 99) < 3);
        end
        idle(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
